// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin owner selection for a shared IO bus with locked bursts,
// one-cycle writes, two-cycle reads and one-hot peripheral enable decode.
module io_bus_arbiter #(
  parameter int CPU_WIDTH = 16,
  parameter int REQ_NUM   = 4,
  parameter int DEV_NUM   = 3,
  parameter int HOLD_MAX  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [REQ_NUM-1:0]             req,
  input  logic [REQ_NUM*CPU_WIDTH-1:0]   req_addr,
  input  logic [REQ_NUM-1:0]             req_ctrl,
  input  logic [REQ_NUM-1:0]             lock,
  output logic [REQ_NUM-1:0]             gnt,
  output logic [REQ_NUM-1:0]             done,
  output logic                           err,
  output logic [CPU_WIDTH-1:0]           bus_addr,
  output logic                           bus_ctrl,
  output logic [DEV_NUM-1:0]             dev_en,
  output logic                           busy
);
  localparam int IW = REQ_NUM > 1 ? $clog2(REQ_NUM) : 1;
  localparam int HW = HOLD_MAX > 1 ? $clog2(HOLD_MAX) : 1;
  typedef enum logic [1:0] {IDLE, XFER, RWAIT} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] win_q, win_d, last_q, last_d, pick_c, cand_c;
  logic [HW-1:0] hold_q, hold_d;
  logic [CPU_WIDTH-1:0] addr_q, addr_d;
  logic ctrl_q, ctrl_d;
  logic [CPU_WIDTH-1:0] addr_arr [REQ_NUM];
  logic [1:0] dev_idx;
  logic dev_ok, done_c, relock_c;
  for (genvar g = 0; g < REQ_NUM; g++) begin : g_addr
    assign addr_arr[g] = req_addr[g*CPU_WIDTH +: CPU_WIDTH];
  end
  // Scan from the farthest candidate down so the nearest requester after last wins.
  always_comb begin
    pick_c = last_q;
    cand_c = '0;
    for (int k = REQ_NUM; k >= 1; k--) begin
      cand_c = IW'((int'(last_q) + k) % REQ_NUM);
      if (req[cand_c]) pick_c = cand_c;
    end
  end
  assign busy     = state_q != IDLE;
  assign done_c   = (state_q == XFER && ctrl_q) || state_q == RWAIT;
  assign relock_c = lock[win_q] && req[win_q] && int'(hold_q) < HOLD_MAX - 1;
  assign dev_idx  = addr_q[CPU_WIDTH-1 -: 2];
  assign dev_ok   = int'(dev_idx) < DEV_NUM;
  assign bus_addr = addr_q;
  assign bus_ctrl = ctrl_q;
  assign gnt      = busy ? REQ_NUM'(1) << win_q : '0;
  assign done     = done_c ? REQ_NUM'(1) << win_q : '0;
  assign dev_en   = (busy && dev_ok) ? DEV_NUM'(1) << dev_idx : '0;
  assign err      = done_c && !dev_ok;
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    addr_d  = addr_q;
    ctrl_d  = ctrl_q;
    last_d  = last_q;
    hold_d  = hold_q;
    if (state_q == IDLE) begin
      if (|req) begin
        state_d = XFER;
        win_d   = pick_c;
        addr_d  = addr_arr[pick_c];
        ctrl_d  = req_ctrl[pick_c];
      end
    end else if (!done_c) begin
      state_d = RWAIT;
    end else if (relock_c) begin
      state_d = XFER;
      addr_d  = addr_arr[win_q];
      ctrl_d  = req_ctrl[win_q];
      hold_d  = hold_q + 1'b1;
    end else begin
      state_d = IDLE;
      last_d  = win_q;
      hold_d  = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      addr_q  <= '0;
      ctrl_q  <= 1'b0;
      last_q  <= IW'(REQ_NUM - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      ctrl_q  <= ctrl_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: directed scenarios plus random traffic, checked by a
// transaction-level predictor feeding a done-driven scoreboard.
module tb_io_bus_arbiter;
  localparam int CW = 16;
  localparam int RN = 4;
  localparam int DN = 3;
  localparam int HM = 8;
  logic clk = 0;
  logic rst = 1;
  logic [RN-1:0] req = '0;
  logic [RN-1:0] req_ctrl = '0;
  logic [RN-1:0] lock = '0;
  logic [RN*CW-1:0] req_addr = '0;
  logic [RN-1:0] gnt, done;
  logic err, bus_ctrl, busy;
  logic [CW-1:0] bus_addr;
  logic [DN-1:0] dev_en;
  int asserts = 0;
  int fails = 0;
  int n = 0;
  typedef struct {int cyc; int w; logic [CW-1:0] addr; logic ctrl;} exp_t;
  exp_t q[$];
  int seen[$];
  int m_last = RN - 1;
  int m_hold = 0;
  int m_w = 0;
  int m_end = 0;
  bit m_busy = 0;

  always #5 clk = ~clk;

  io_bus_arbiter #(.CPU_WIDTH(CW), .REQ_NUM(RN), .DEV_NUM(DN), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_ctrl(req_ctrl),
    .lock(lock), .gnt(gnt), .done(done), .err(err), .bus_addr(bus_addr),
    .bus_ctrl(bus_ctrl), .dev_en(dev_en), .busy(busy)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, n);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DN-1:0] dev_of(logic [CW-1:0] a);
    int d = int'(a[CW-1 -: 2]);
    return d < DN ? DN'(1) << d : '0;
  endfunction

  function automatic int rr(int last, logic [RN-1:0] r);
    for (int k = 1; k <= RN; k++) if (r[(last + k) % RN]) return (last + k) % RN;
    return -1;
  endfunction

  // A transfer latched at edge n finishes in the same cycle (write) or one later (read).
  task automatic start(int w);
    exp_t e;
    e.w = w;
    e.addr = req_addr[w*CW +: CW];
    e.ctrl = req_ctrl[w];
    e.cyc = n + (e.ctrl ? 0 : 1);
    q.push_back(e);
    m_w = w;
    m_end = n + (e.ctrl ? 1 : 2);
    m_busy = 1;
  endtask

  initial forever begin
    @(posedge clk);
    n++;
    if (rst) begin
      while (q.size() > 0 && q[q.size()-1].cyc >= n) q.delete(q.size() - 1);
      m_busy = 0;
      m_last = RN - 1;
      m_hold = 0;
    end else if (m_busy) begin
      if (n == m_end) begin
        if (lock[m_w] && req[m_w] && m_hold < HM - 1) begin
          m_hold++;
          start(m_w);
        end else begin
          m_last = m_w;
          m_hold = 0;
          m_busy = 0;
        end
      end
    end else if (req != 0) begin
      start(rr(m_last, req));
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc < n) begin
        asserts++;
        fails++;
        $display("FAIL missed_done: got none expected done[%0d] at cycle %0d", q[0].w, q[0].cyc);
        q.delete(0);
      end
      if (done != 0) begin
        if (q.size() == 0) chk("spurious_done", 64'(done), 0);
        else begin
          e = q.pop_front();
          chk("done_cycle", n, e.cyc);
          chk("done_owner", 64'(done), 1 << e.w);
          chk("gnt", 64'(gnt), 1 << e.w);
          chk("bus_addr", 64'(bus_addr), 64'(e.addr));
          chk("bus_ctrl", 64'(bus_ctrl), 64'(e.ctrl));
          chk("dev_en", 64'(dev_en), 64'(dev_of(e.addr)));
          chk("err", 64'(err), 64'(int'(e.addr[CW-1 -: 2]) >= DN));
        end
        for (int i = 0; i < RN; i++) if (done[i]) seen.push_back(i);
      end
      if (!busy) chk("idle_outputs", 64'({gnt, done, dev_en, err}), 0);
    end
  end

  initial begin
    int ord[5] = '{0, 1, 2, 3, 0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 64'(gnt), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_bus", 64'({bus_addr, bus_ctrl}), 0);
    chk("rst_misc", 64'({done, dev_en, err}), 0);
    tick;
    rst = 0;
    seen.delete();
    req = 4'hF;
    req_ctrl = 4'hF;
    req_addr = {16'h0003, 16'h0002, 16'h0001, 16'h0000};
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("rr_count", seen.size(), 5);
    for (int i = 0; i < 5; i++) chk("rr_order", seen[i], ord[i]);
    tick;
    req = '0;
    tick;
    req = 4'b0100;
    req_ctrl = '0;
    req_addr[2*CW +: CW] = 16'h4005;
    tick;
    req = '0;
    @(negedge clk);
    chk("rd_xfer_gnt", 64'(gnt), 4'b0100);
    chk("rd_xfer_dev", 64'(dev_en), 3'b010);
    chk("rd_xfer_nodone", 64'(done), 0);
    tick;
    @(negedge clk);
    chk("rd_wait_gnt", 64'(gnt), 4'b0100);
    chk("rd_wait_done", 64'(done), 4'b0100);
    chk("rd_wait_err", 64'(err), 0);
    tick;
    @(negedge clk);
    chk("idle_hold_addr", 64'(bus_addr), 16'h4005);
    tick;
    req = 4'b0001;
    req_ctrl = 4'b0001;
    req_addr[0 +: CW] = 16'hC000;
    tick;
    req = '0;
    @(negedge clk);
    chk("oor_dev", 64'(dev_en), 0);
    chk("oor_err", 64'(err), 1);
    chk("oor_done", 64'(done), 4'b0001);
    tick;
    req = 4'b0011;
    lock = 4'b0010;
    req_ctrl = 4'hF;
    req_addr[CW +: CW] = 16'h8010;
    req_addr[0 +: CW] = 16'h0020;
    tick;
    for (int i = 0; i < HM; i++) begin
      @(negedge clk);
      chk("lock_gnt", 64'(gnt), 4'b0010);
      chk("lock_done", 64'(done), 4'b0010);
      tick;
    end
    @(negedge clk);
    chk("lock_end_gnt", 64'(gnt), 0);
    chk("lock_end_busy", 64'(busy), 0);
    tick;
    req = '0;
    lock = '0;
    @(negedge clk);
    chk("lock_next_gnt", 64'(gnt), 4'b0001);
    tick;
    req = 4'b0001;
    req_ctrl = '0;
    req_addr[0 +: CW] = 16'h0100;
    tick;
    req = '0;
    @(negedge clk);
    chk("drop_xfer_gnt", 64'(gnt), 4'b0001);
    chk("drop_xfer_done", 64'(done), 0);
    tick;
    @(negedge clk);
    chk("drop_wait_done", 64'(done), 4'b0001);
    tick;
    req = 4'b0100;
    req_ctrl = '0;
    tick;
    req = '0;
    tick;
    rst = 1;
    @(negedge clk);
    chk("rst_rwait_done", 64'(done), 4'b0100);
    tick;
    rst = 0;
    req = 4'b1010;
    @(negedge clk);
    chk("rst_mid_outputs", 64'({gnt, done, dev_en, err, busy, bus_addr, bus_ctrl}), 0);
    tick;
    req = '0;
    @(negedge clk);
    chk("rst_first_gnt", 64'(gnt), 4'b0010);
    repeat (3) tick;
    repeat (3000) begin
      tick;
      rst = $urandom_range(0, 99) == 0;
      req = RN'($urandom | $urandom);
      req_ctrl = RN'($urandom);
      lock = RN'($urandom | $urandom);
      req_addr = {$urandom, $urandom};
    end
    tick;
    rst = 0;
    req = '0;
    lock = '0;
    repeat (6) tick;
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/io_bus_arbiter.md
IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 SHALL have parameter CPU_WIDTH, default 16, bus address width.
REQ-002 SHALL have parameter REQ_NUM, default 4, number of requesters.
REQ-003 SHALL have parameter DEV_NUM, default 3, number of peripherals; legal range 1..4.
REQ-004 SHALL have parameter HOLD_MAX, default 8, maximum number of back-to-back locked transfers per grant.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-007 SHALL have port req, input, REQ_NUM, per-requester transfer request.
REQ-008 SHALL have port req_addr, input, REQ_NUM*CPU_WIDTH, packed addresses, requester i in bits [i*CPU_WIDTH +: CPU_WIDTH].
REQ-009 SHALL have port req_ctrl, input, REQ_NUM, per-requester direction: 1 = write (IO_CTRL_WRITE), 0 = read (IO_CTRL_READ).
REQ-010 SHALL have port lock, input, REQ_NUM, per-requester request to keep ownership after the current transfer.
REQ-011 SHALL have port gnt, output, REQ_NUM, one-hot grant to the bus owner.
REQ-012 SHALL have port done, output, REQ_NUM, one-cycle completion pulse to the owner; for reads, the owner samples the data bus in this cycle.
REQ-013 SHALL have port err, output, 1, pulse with done when the decoded device index is >= DEV_NUM.
REQ-014 SHALL have ports bus_addr (CPU_WIDTH) and bus_ctrl (1), outputs, address and direction driven to all peripherals.
REQ-015 SHALL have port dev_en, output, DEV_NUM, one-hot peripheral enable (EN of the selected device).
REQ-016 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-017 SHALL implement the states IDLE, XFER and RWAIT; all outputs SHALL be registered or decoded from registered state only.
REQ-018 In IDLE with req != 0, the block SHALL select a winner round-robin, searching from index (last+1) mod REQ_NUM upward; it SHALL latch winner, req_addr and req_ctrl, and enter XFER on the next edge.
REQ-019 In XFER and RWAIT: gnt[winner]=1; bus_addr and bus_ctrl SHALL hold the latched values; dev_en[bus_addr[CPU_WIDTH-1:CPU_WIDTH-2]]=1 when that index is < DEV_NUM, else dev_en=0.
REQ-020 Write: XFER SHALL last 1 cycle, with done[winner]=1 in that cycle (request-to-done latency 2 edges).
REQ-021 Read: XFER (1 cycle) SHALL be followed by RWAIT (1 cycle), covering the peripheral's registered output buffer; done[winner]=1 in RWAIT only.
REQ-022 Out-of-range device index: the transfer timing SHALL be unchanged, dev_en SHALL stay 0, and err=1 in the done cycle.
REQ-023 In the done cycle, if lock[winner]=1 and req[winner]=1 and hold_cnt < HOLD_MAX-1, the block SHALL re-latch that requester's addr/ctrl, increment hold_cnt and go to XFER with gnt held continuously; otherwise it SHALL set last=winner, clear hold_cnt and go to IDLE.
REQ-024 req deassertion during XFER/RWAIT SHALL NOT abort the transfer; req, addr, ctrl and lock SHALL be sampled only in IDLE or in the done cycle.
REQ-025 In IDLE: gnt, done, dev_en and err SHALL be 0 and bus_addr/bus_ctrl SHALL hold their last values; there SHALL be at least one IDLE cycle between different owners.
REQ-026 With a single active requester, back-to-back unlocked writes SHALL achieve one transfer per 2 cycles.

Reset
REQ-027 With rst=1 at an edge, the block SHALL enter IDLE from any state, including mid-transfer, and set gnt=0, done=0, err=0, dev_en=0, busy=0, bus_addr=0, bus_ctrl=0 (read), hold_cnt=0 and last=REQ_NUM-1, so requester 0 has first priority.
REQ-028 A transfer interrupted by reset SHALL produce no done pulse.

Verification
REQ-029 A bench SHALL cover: after reset, req=4'b1111, all writes, no lock -> grants in order 0,1,2,3,0, each with a 1-cycle XFER.
REQ-030 A bench SHALL cover: requester 2 reads addr 16'h4005 -> gnt[2] for 2 cycles, dev_en=3'b010, done[2] in the 2nd cycle, err=0.
REQ-031 A bench SHALL cover: write to addr 16'hC000 with DEV_NUM=3 -> dev_en=0, err=1 and done pulse in the same cycle.
REQ-032 A bench SHALL cover: requester 1 holds lock=1 and req=1 with requester 0 also requesting -> exactly 8 consecutive transfers to 1 with gnt[1] continuous, then IDLE, then grant to 0.
REQ-033 A bench SHALL cover: rst=1 asserted in RWAIT -> next edge all outputs 0, busy=0, no done; the first grant afterwards goes to the lowest requesting index.
REQ-034 A bench SHALL cover: req[0] dropped during XFER of a read -> RWAIT and done[0] still occur.
